// File: rtl/alu_seq_if.sv
// Request/response handshake bundle for alu_seq.
// The requester drives the request and out_ready; the ALU drives the rest.
interface alu_seq_if #(
    parameter int WIDTH = 64,
    parameter int OPW   = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [OPW-1:0]   opcode;
    logic [WIDTH-1:0] value1;
    logic [WIDTH-1:0] value2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             error;

    modport master (
        output in_valid, opcode, value1, value2, out_ready,
        input  in_ready, out_valid, result, error
    );

    modport slave (
        input  in_valid, opcode, value1, value2, out_ready,
        output in_ready, out_valid, result, error
    );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith ops plus an iterative restoring
// divider for DIV/REM, fronted by a valid/ready request and result handshake.
module alu_seq #(
    parameter int WIDTH = 64,
    parameter int OPW   = 8
) (
    input  logic     clk,
    input  logic     reset,
    alu_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [OPW-1:0] OP_ADD = OPW'(0);
    localparam logic [OPW-1:0] OP_SUB = OPW'(1);
    localparam logic [OPW-1:0] OP_MUL = OPW'(2);
    localparam logic [OPW-1:0] OP_DIV = OPW'(3);
    localparam logic [OPW-1:0] OP_XOR = OPW'(4);
    localparam logic [OPW-1:0] OP_AND = OPW'(5);
    localparam logic [OPW-1:0] OP_OR  = OPW'(6);
    localparam logic [OPW-1:0] OP_REM = OPW'(7);
    localparam logic [OPW-1:0] OP_NOT = OPW'(8);

    typedef enum logic [1:0] {IDLE, DIVIDE, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] result_q;
    logic             error_q;
    logic             valid_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic             is_rem_q;
    logic [CW-1:0]    cnt_q;

    logic             accept;
    logic             is_div_op;
    logic [WIDTH-1:0] sc_res;
    logic             sc_err;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;
    logic             ge;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] quo_d;

    assign bus.in_ready  = (state_q == IDLE) || (state_q == DONE && bus.out_ready);
    assign bus.out_valid = valid_q;
    assign bus.result    = result_q;
    assign bus.error     = error_q;

    assign accept    = bus.in_valid && bus.in_ready;
    assign is_div_op = (bus.opcode == OP_DIV) || (bus.opcode == OP_REM);

    // Divide-by-zero never enters DIVIDE; it resolves here like any single-cycle op.
    always_comb begin
        sc_res = '0;
        sc_err = 1'b0;
        case (bus.opcode)
            OP_ADD: sc_res = bus.value1 + bus.value2;
            OP_SUB: sc_res = bus.value1 - bus.value2;
            OP_MUL: sc_res = bus.value1 * bus.value2;
            OP_DIV: begin sc_res = '1;         sc_err = 1'b1; end
            OP_XOR: sc_res = bus.value1 ^ bus.value2;
            OP_AND: sc_res = bus.value1 & bus.value2;
            OP_OR:  sc_res = bus.value1 | bus.value2;
            OP_REM: begin sc_res = bus.value1; sc_err = 1'b1; end
            OP_NOT: sc_res = ~bus.value1;
            default: begin sc_res = '0;        sc_err = 1'b1; end
        endcase
    end

    // One restoring step: shift the next dividend bit into the partial remainder,
    // subtract when it fits. The borrow bit of the W+1-bit difference is the compare.
    always_comb begin
        rem_sh = {rem_q, quo_q[WIDTH-1]};
        diff   = rem_sh - {1'b0, dvs_q};
        ge     = ~diff[WIDTH];
        rem_d  = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        quo_d  = {quo_q[WIDTH-2:0], ge};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            result_q <= '0;
            error_q  <= 1'b0;
            valid_q  <= 1'b0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            is_rem_q <= 1'b0;
            cnt_q    <= '0;
        end else if (accept) begin
            if (is_div_op && bus.value2 != '0) begin
                state_q  <= DIVIDE;
                valid_q  <= 1'b0;
                rem_q    <= '0;
                quo_q    <= bus.value1;
                dvs_q    <= bus.value2;
                is_rem_q <= (bus.opcode == OP_REM);
                cnt_q    <= CW'(WIDTH - 1);
            end else begin
                state_q  <= DONE;
                valid_q  <= 1'b1;
                result_q <= sc_res;
                error_q  <= sc_err;
            end
        end else begin
            case (state_q)
                DIVIDE: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        state_q  <= DONE;
                        valid_q  <= 1'b1;
                        result_q <= is_rem_q ? rem_d : quo_d;
                        error_q  <= 1'b0;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed corner cases plus randomized traffic
// against an arithmetic reference model, with a decoupled output monitor.
module tb_alu_seq;
    localparam int W   = 64;
    localparam int OPW = 8;

    typedef struct packed {
        logic [W-1:0] res;
        logic         err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(W), .OPW(OPW)) bus ();

    alu_seq #(.WIDTH(W), .OPW(OPW)) u_dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    exp_t sb[$];
    int   xfer_cyc[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    bit   rnd_or = 1'b0;

    always @(posedge clk) cyc++;

    function automatic exp_t model(input logic [OPW-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.err = 1'b0;
        case (op)
            0: e.res = a + b;
            1: e.res = a - b;
            2: e.res = a * b;
            3: if (b == 0) begin e.res = '1; e.err = 1'b1; end else e.res = a / b;
            4: e.res = a ^ b;
            5: e.res = a & b;
            6: e.res = a | b;
            7: if (b == 0) begin e.res = a;  e.err = 1'b1; end else e.res = a % b;
            8: e.res = ~a;
            default: begin e.res = '0; e.err = 1'b1; end
        endcase
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every transfer pops the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: got result %h with nothing expected", bus.result);
                end else begin
                    e = sb.pop_front();
                    check("result", bus.result, e.res);
                    check("error", 64'(bus.error), 64'(e.err));
                end
                xfer_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_or) bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [OPW-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b, output int waited);
        bit ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.opcode   = op;
        bus.value1   = a;
        bus.value2   = b;
        waited       = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            waited++;
            if (bus.in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: got in_ready 0 for %0d cycles expected 1", waited);
            bus.in_valid = 1'b0;
            @(posedge clk);
            #1;
        end else begin
            sb.push_back(model(op, a, b));
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic wait_valid(output int k);
        k = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            k++;
            if (bus.out_valid === 1'b1) return;
        end
        k = -1;
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w, w1, w2, w3, k, n0;
        logic [W-1:0] a, b;
        logic [OPW-1:0] op;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.opcode    = '0;
        bus.value1    = '0;
        bus.value2    = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_result", bus.result, 64'd0);
        check("reset_error", 64'(bus.error), 64'd0);
        check("reset_in_ready", 64'(bus.in_ready), 64'd1);
        rst_n = 1'b1;

        send(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, w);
        check("first_accept_wait", 64'(w), 64'd1);
        wait_valid(k);
        check("add_latency", 64'(k), 64'd1);
        sync();

        send(3, 64'd100, 64'd7, w);
        wait_valid(k);
        check("div_latency", 64'(k), 64'(W + 1));
        sync();
        send(7, 64'd100, 64'd7, w);
        wait_valid(k);
        check("rem_latency", 64'(k), 64'(W + 1));
        sync();

        send(3, 64'd5, 64'd0, w);
        wait_valid(k);
        check("div0_latency", 64'(k), 64'd1);
        sync();
        send(7, 64'd5, 64'd0, w);
        wait_valid(k);
        check("rem0_latency", 64'(k), 64'd1);
        sync();

        xfer_cyc.delete();
        send(0, {$urandom(), $urandom()}, {$urandom(), $urandom()}, w1);
        send(4, {$urandom(), $urandom()}, {$urandom(), $urandom()}, w2);
        send(6, {$urandom(), $urandom()}, {$urandom(), $urandom()}, w3);
        check("b2b_wait0", 64'(w1), 64'd1);
        check("b2b_wait1", 64'(w2), 64'd1);
        check("b2b_wait2", 64'(w3), 64'd1);
        repeat (3) sync();
        check("b2b_count", 64'(xfer_cyc.size()), 64'd3);
        if (xfer_cyc.size() == 3) begin
            check("b2b_gap0", 64'(xfer_cyc[1] - xfer_cyc[0]), 64'd1);
            check("b2b_gap1", 64'(xfer_cyc[2] - xfer_cyc[1]), 64'd1);
        end

        bus.out_ready = 1'b0;
        send(2, 64'd3, 64'd4, w);
        bus.in_valid = 1'b1;
        bus.opcode   = 8'd0;
        bus.value1   = 64'd77;
        bus.value2   = 64'd88;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", 64'(bus.out_valid), 64'd1);
            check("hold_result", bus.result, 64'd12);
            check("hold_in_ready", 64'(bus.in_ready), 64'd0);
        end
        sync();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) sync();
        check("hold_drained", 64'(sb.size()), 64'd0);
        check("hold_no_extra", 64'(bus.out_valid), 64'd0);

        send(3, {$urandom(), $urandom()}, 64'd12345, w);
        repeat (10) sync();
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_result", bus.result, 64'd0);
        check("midrst_error", 64'(bus.error), 64'd0);
        check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        sb.delete();
        n0 = xfer_cyc.size();
        sync();
        rst_n = 1'b1;
        repeat (W + 10) sync();
        check("midrst_no_output", 64'(xfer_cyc.size()), 64'(n0));

        send(9, 64'd1, 64'd2, w);
        send(255, 64'd3, 64'd4, w);
        repeat (2) sync();

        rnd_or = 1'b1;
        for (int n = 0; n < 150; n++) begin
            k  = $urandom_range(0, 10);
            op = (k == 10) ? OPW'($urandom_range(9, 255)) : OPW'(k);
            a  = {$urandom(), $urandom()};
            b  = {$urandom(), $urandom()};
            case ($urandom_range(0, 7))
                0: b = '0;
                1: b = W'($urandom_range(1, 1000));
                2: a = W'($urandom_range(0, 100000));
                default: ;
            endcase
            send(op, a, b, w);
            repeat ($urandom_range(0, 2)) sync();
        end
        rnd_or = 1'b0;
        sync();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 500 && sb.size() != 0; i++) sync();
        check("final_drain", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 64, operand/result width in bits; legal values 8..64, power of two.
REQ-002 Parameter OPW, default 8, opcode width in bits.
REQ-003 Opcode encoding SHALL be fixed: ADD=0, SUB=1, MUL=2, DIV=3, XOR=4, AND=5, OR=6, REM=7, NOT=8; all other values illegal.
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset (asserted when 0).
REQ-006 in_valid  in  1  request present.
REQ-007 in_ready  out  1  block can accept a request this cycle.
REQ-008 opcode  in  OPW  operation select.
REQ-009 value1, value2  in  WIDTH each  operands, unsigned.
REQ-010 out_valid  out  1  result present.
REQ-011 out_ready  in  1  consumer accepts result this cycle.
REQ-012 result  out  WIDTH  operation result.
REQ-013 error  out  1  result belongs to illegal opcode or divide-by-zero; qualified by out_valid.

Function
REQ-014 Request accepted SHALL be in_valid && in_ready at a rising edge; opcode/operands captured at that edge only.
REQ-015 Result transfer SHALL be out_valid && out_ready at a rising edge.
REQ-016 FSM states SHALL be IDLE, DIVIDE, DONE.
REQ-017 IDLE: in_ready=1, out_valid=0; accept of single-cycle op -> DONE; accept of DIV/REM -> DIVIDE.
REQ-018 Single-cycle ops (ADD, SUB, MUL, XOR, AND, OR, NOT, illegal): result registered at accept edge; out_valid=1 in the next cycle (latency 1).
REQ-019 ADD/SUB/MUL SHALL return low WIDTH bits (wrap modulo 2^WIDTH); NOT = ~value1, value2 ignored.
REQ-020 DIV/REM SHALL use an iterative restoring divider, one quotient bit per cycle, WIDTH cycles in DIVIDE; out_valid asserts WIDTH+1 cycles after the accept edge.
REQ-021 DIVIDE: in_ready=0, out_valid=0; iteration counter counts WIDTH-1 down to 0; at 0 -> DONE with quotient (DIV) or remainder (REM) on result.
REQ-022 value2==0 for DIV/REM: no iteration; DONE after 1 cycle; DIV result all-ones, REM result value1, error=1.
REQ-023 Illegal opcode: DONE after 1 cycle, result 0, error=1.
REQ-024 DONE: out_valid=1; result/error held stable while out_ready=0.
REQ-025 in_ready SHALL equal (state==IDLE) || (state==DONE && out_ready); combinational from out_ready.
REQ-026 DONE with out_ready=1 and in_valid=1: new request accepted same edge (throughput 1/cycle for single-cycle ops); next state per REQ-017.
REQ-027 DONE with out_ready=1 and in_valid=0: -> IDLE.
REQ-028 Inputs ignored while in_ready=0; in_valid may drop without effect.

Reset
REQ-029 reset low SHALL asynchronously force state=IDLE, out_valid=0, error=0, result=0, counter=0, divider registers=0.
REQ-030 Reset mid-DIVIDE SHALL abandon the operation; no result produced after release.
REQ-031 First accept possible at first rising edge with reset high.

Verification
REQ-032 ADD 0xFFFF_FFFF_FFFF_FFFF + 1, out_ready=1 -> next cycle out_valid=1, result 0, error 0.
REQ-033 DIV 100/7 accepted at edge T -> out_valid at T+65 (WIDTH=64), result 14; REM same operands -> 2.
REQ-034 DIV 5/0 -> result 0xFFFF_FFFF_FFFF_FFFF, error 1, latency 1; REM 5/0 -> result 5, error 1.
REQ-035 Back-to-back ADD, XOR, OR with in_valid and out_ready held 1 -> three results on three consecutive cycles, in_ready constant 1.
REQ-036 MUL 3*4 with out_ready=0 for 5 cycles -> result 12 held, in_ready 0, new requests ignored; released on out_ready=1.
REQ-037 Start DIV, assert reset low at cycle 10 of DIVIDE -> outputs zero immediately, IDLE, no out_valid after release; opcode 9 -> result 0, error 1.
